// File: rtl/sprockell_pkg.sv
// sprockell_pkg: shared defaults and load-pipeline entry types for the Sprockell register file
package sprockell_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_ZERO = 0;
  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_idx_t;
  typedef struct packed {
    logic     valid;
    reg_idx_t dst;
  } ld_entry_t;
endpackage

// File: rtl/sprockell_ld_delay.sv
// sprockell_ld_delay: LOAD_LAT-deep shift pipeline of load entries with flush, all stages exposed
module sprockell_ld_delay
  import sprockell_pkg::*;
#(
  parameter int  LOAD_LAT = 2,
  parameter type entry_t  = ld_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  entry_t ent,
  output entry_t stg [LOAD_LAT]
);
  entry_t stg_q [LOAD_LAT];
  entry_t stg_d [LOAD_LAT];
  always_comb begin
    stg_d[0] = flush ? '0 : ent;
    for (int i = 1; i < LOAD_LAT; i++) stg_d[i] = flush ? '0 : stg_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < LOAD_LAT; i++) stg_q[i] <= '0;
    else stg_q <= stg_d;
  end
  assign stg = stg_q;
endmodule

// File: rtl/sprockell_regfile_lsu.sv
// sprockell_regfile_lsu: register file with delayed-load writeback, load bypass and hazard stall
module sprockell_regfile_lsu
  import sprockell_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = $clog2(LOAD_LAT + 1)
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic [IDX_W-1:0]  rd_a_idx,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [IDX_W-1:0]  rd_b_idx,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              alu_we,
  input  logic [IDX_W-1:0]  alu_wr_idx,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic              ld_issue,
  input  logic [IDX_W-1:0]  ld_dst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ld_flush,
  output logic              stall,
  output logic [CNT_W-1:0]  ld_outstanding,
  output logic              collision_err
);
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] dst;
  } entry_t;
  localparam logic [IDX_W-1:0] ZERO = IDX_W'(REG_ZERO);
  entry_t ent;
  entry_t cmp;
  entry_t stg [LOAD_LAT];
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic collision_q, collision_d;
  logic cmp_wr;
  assign ent = '{valid: ld_issue && ld_dst != ZERO, dst: ld_dst};
  sprockell_ld_delay #(.LOAD_LAT(LOAD_LAT), .entry_t(entry_t)) u_ld_delay (
    .clk  (system1000),
    .rst_n(system1000_rstn),
    .flush(ld_flush),
    .ent  (ent),
    .stg  (stg)
  );
  assign cmp = stg[LOAD_LAT-1];
  assign cmp_wr = cmp.valid && !ld_flush;
  // Load data is written after the ALU so it wins a same-register collision.
  always_comb begin
    regs_d = regs_q;
    if (alu_we) regs_d[alu_wr_idx] = alu_wr_data;
    if (cmp_wr) regs_d[cmp.dst] = mem_rdata;
    regs_d[0] = '0;
    collision_d = collision_q | (alu_we && cmp_wr && alu_wr_idx == cmp.dst);
  end
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      collision_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      collision_q <= collision_d;
    end
  end
  always_comb begin
    rd_a_data = rd_a_idx == ZERO ? '0 : (cmp.valid && cmp.dst == rd_a_idx) ? mem_rdata : regs_q[rd_a_idx];
    rd_b_data = rd_b_idx == ZERO ? '0 : (cmp.valid && cmp.dst == rd_b_idx) ? mem_rdata : regs_q[rd_b_idx];
  end
  // Only stages that have not yet reached completion can cause a hazard.
  always_comb begin
    stall = 1'b0;
    ld_outstanding = '0;
    for (int k = 0; k < LOAD_LAT - 1; k++)
      stall = stall | (stg[k].valid && ((rd_a_idx != ZERO && stg[k].dst == rd_a_idx) ||
                                        (rd_b_idx != ZERO && stg[k].dst == rd_b_idx) ||
                                        (alu_we && stg[k].dst == alu_wr_idx) ||
                                        (ld_issue && stg[k].dst == ld_dst)));
    for (int k = 0; k < LOAD_LAT; k++) ld_outstanding = ld_outstanding + CNT_W'(stg[k].valid);
  end
  assign collision_err = collision_q;
endmodule

// File: tb/tb_sprockell_regfile_lsu.sv
// tb_sprockell_regfile_lsu: directed self-checking bench for the register file / load unit
module tb_sprockell_regfile_lsu;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  rd_a_idx = '0, rd_b_idx = '0, alu_wr_idx = '0, ld_dst = '0;
  logic [15:0] rd_a_data, rd_b_data, alu_wr_data = '0, mem_rdata = '0;
  logic        alu_we = 1'b0, ld_issue = 1'b0, ld_flush = 1'b0;
  logic        stall, collision_err;
  logic [1:0]  ld_outstanding;
  int          errs = 0;
  int          checks = 0;
  sprockell_regfile_lsu dut (
    .system1000     (clk),
    .system1000_rstn(rstn),
    .rd_a_idx       (rd_a_idx),
    .rd_a_data      (rd_a_data),
    .rd_b_idx       (rd_b_idx),
    .rd_b_data      (rd_b_data),
    .alu_we         (alu_we),
    .alu_wr_idx     (alu_wr_idx),
    .alu_wr_data    (alu_wr_data),
    .ld_issue       (ld_issue),
    .ld_dst         (ld_dst),
    .mem_rdata      (mem_rdata),
    .ld_flush       (ld_flush),
    .stall          (stall),
    .ld_outstanding (ld_outstanding),
    .collision_err  (collision_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #12;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_outstanding", 32'(ld_outstanding), 0);
    chk("rst_collision", 32'(collision_err), 0);
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      rd_a_idx = 5'(i);
      rd_b_idx = 5'(31 - i);
      #1;
      chk("rst_rd_a", 32'(rd_a_data), 0);
      chk("rst_rd_b", 32'(rd_b_data), 0);
    end
    alu_we = 1'b1; alu_wr_idx = 5'd7; alu_wr_data = 16'h00A5; rd_a_idx = 5'd7; rd_b_idx = 5'd0;
    #1;
    chk("alu_same_cycle", 32'(rd_a_data), 32'h0000);
    tick();
    alu_we = 1'b0;
    #1;
    chk("alu_next_cycle", 32'(rd_a_data), 32'h00A5);
    alu_we = 1'b1; alu_wr_idx = 5'd0; alu_wr_data = 16'hFFFF; rd_a_idx = 5'd0; rd_b_idx = 5'd7;
    tick();
    alu_we = 1'b0;
    #1;
    chk("r0_ignored", 32'(rd_a_data), 32'h0000);
    chk("r7_kept", 32'(rd_b_data), 32'h00A5);
    ld_issue = 1'b1; ld_dst = 5'd7; rd_a_idx = 5'd7; rd_b_idx = 5'd0;
    #1;
    chk("ld_c0_stall", 32'(stall), 0);
    tick();
    ld_issue = 1'b0;
    #1;
    chk("ld_c1_stall", 32'(stall), 1);
    chk("ld_c1_outstanding", 32'(ld_outstanding), 1);
    chk("ld_c1_old", 32'(rd_a_data), 32'h00A5);
    tick();
    mem_rdata = 16'h1234;
    #1;
    chk("ld_c2_bypass", 32'(rd_a_data), 32'h1234);
    chk("ld_c2_stall", 32'(stall), 0);
    tick();
    mem_rdata = 16'h0000;
    #1;
    chk("ld_c3_array", 32'(rd_a_data), 32'h1234);
    chk("ld_c3_outstanding", 32'(ld_outstanding), 0);
    rd_a_idx = 5'd0;
    ld_issue = 1'b1; ld_dst = 5'd3;
    tick();
    ld_dst = 5'd4;
    #1;
    chk("b2b_c1_outstanding", 32'(ld_outstanding), 1);
    tick();
    ld_dst = 5'd5; mem_rdata = 16'h0003;
    #1;
    chk("b2b_c2_outstanding", 32'(ld_outstanding), 2);
    chk("b2b_c2_no_waw", 32'(stall), 0);
    tick();
    ld_issue = 1'b0; mem_rdata = 16'h0004; rd_a_idx = 5'd3;
    #1;
    chk("b2b_c3_outstanding", 32'(ld_outstanding), 2);
    chk("b2b_r3", 32'(rd_a_data), 32'h0003);
    tick();
    mem_rdata = 16'h0005; rd_a_idx = 5'd4;
    #1;
    chk("b2b_c4_outstanding", 32'(ld_outstanding), 1);
    chk("b2b_r4", 32'(rd_a_data), 32'h0004);
    tick();
    mem_rdata = 16'h0000; rd_b_idx = 5'd5;
    #1;
    chk("b2b_c5_outstanding", 32'(ld_outstanding), 0);
    chk("b2b_r5", 32'(rd_b_data), 32'h0005);
    chk("b2b_r3_kept", 32'(rd_a_data), 32'h0004);
    rd_a_idx = 5'd0; rd_b_idx = 5'd0;
    ld_issue = 1'b1; ld_dst = 5'd0;
    tick();
    ld_issue = 1'b0;
    #1;
    chk("ld_r0_uncounted", 32'(ld_outstanding), 0);
    ld_issue = 1'b1; ld_dst = 5'd10;
    tick();
    ld_issue = 1'b0; alu_wr_idx = 5'd10; alu_wr_data = 16'h0055; alu_we = 1'b0;
    #1;
    chk("waw_alu_off", 32'(stall), 0);
    alu_we = 1'b1;
    #1;
    chk("waw_alu_on", 32'(stall), 1);
    ld_issue = 1'b1; ld_dst = 5'd10; alu_we = 1'b0;
    #1;
    chk("waw_ld_issue", 32'(stall), 1);
    ld_issue = 1'b0; alu_we = 1'b1;
    tick();
    alu_we = 1'b0; mem_rdata = 16'h0066; rd_a_idx = 5'd10;
    #1;
    chk("waw_bypass", 32'(rd_a_data), 32'h0066);
    tick();
    mem_rdata = 16'h0000;
    #1;
    chk("waw_final", 32'(rd_a_data), 32'h0066);
    chk("waw_no_collision", 32'(collision_err), 0);
    ld_issue = 1'b1; ld_dst = 5'd11;
    tick();
    ld_issue = 1'b0;
    tick();
    alu_we = 1'b1; alu_wr_idx = 5'd12; alu_wr_data = 16'hABCD; mem_rdata = 16'h2222;
    tick();
    alu_we = 1'b0; mem_rdata = 16'h0000; rd_a_idx = 5'd11; rd_b_idx = 5'd12;
    #1;
    chk("diff_reg_ld", 32'(rd_a_data), 32'h2222);
    chk("diff_reg_alu", 32'(rd_b_data), 32'hABCD);
    chk("diff_reg_no_collision", 32'(collision_err), 0);
    ld_issue = 1'b1; ld_dst = 5'd9;
    tick();
    ld_issue = 1'b0;
    tick();
    alu_we = 1'b1; alu_wr_idx = 5'd9; alu_wr_data = 16'h7777; mem_rdata = 16'h1111;
    tick();
    alu_we = 1'b0; mem_rdata = 16'h0000; rd_a_idx = 5'd9;
    #1;
    chk("collision_data", 32'(rd_a_data), 32'h1111);
    chk("collision_flag", 32'(collision_err), 1);
    alu_we = 1'b1; alu_wr_idx = 5'd6; alu_wr_data = 16'h0606;
    tick();
    alu_we = 1'b0;
    ld_issue = 1'b1; ld_dst = 5'd6;
    tick();
    ld_flush = 1'b1; ld_dst = 5'd8;
    #1;
    chk("flush_c1_outstanding", 32'(ld_outstanding), 1);
    tick();
    ld_flush = 1'b0; ld_issue = 1'b0; mem_rdata = 16'hBEEF; rd_a_idx = 5'd6; rd_b_idx = 5'd8;
    #1;
    chk("flush_c2_outstanding", 32'(ld_outstanding), 0);
    chk("flush_c2_no_bypass", 32'(rd_a_data), 32'h0606);
    tick();
    mem_rdata = 16'h0000;
    #1;
    chk("flush_r6_kept", 32'(rd_a_data), 32'h0606);
    chk("flush_r8_dropped", 32'(rd_b_data), 32'h0000);
    ld_issue = 1'b1; ld_dst = 5'd13; rd_a_idx = 5'd13;
    tick();
    ld_issue = 1'b0;
    tick();
    mem_rdata = 16'hDEAD; ld_flush = 1'b1;
    #1;
    chk("flush_cmp_bypass", 32'(rd_a_data), 32'hDEAD);
    tick();
    ld_flush = 1'b0; mem_rdata = 16'h0000;
    #1;
    chk("flush_cmp_no_write", 32'(rd_a_data), 32'h0000);
    chk("collision_sticky", 32'(collision_err), 1);
    ld_issue = 1'b1; ld_dst = 5'd14; rd_a_idx = 5'd7; rd_b_idx = 5'd14;
    tick();
    ld_issue = 1'b0;
    #1;
    chk("pre_rst_outstanding", 32'(ld_outstanding), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_outstanding", 32'(ld_outstanding), 0);
    chk("mid_rst_collision", 32'(collision_err), 0);
    chk("mid_rst_r7", 32'(rd_a_data), 32'h0000);
    tick();
    #3;
    rstn = 1'b1;
    mem_rdata = 16'h4444;
    tick();
    tick();
    mem_rdata = 16'h0000;
    #1;
    chk("post_rst_r14", 32'(rd_b_data), 32'h0000);
    chk("post_rst_outstanding", 32'(ld_outstanding), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sprockell_regfile_lsu.md
Name: sprockell_regfile_lsu

Overview:
Parametrised register file with a delayed-load writeback unit for the Sprockell core. It generalises the fixed 32x16 register array and 5-bit load-address buffer of the single-cycle core: depth, data width and shared-memory load latency are configurable. It tracks in-flight loads, forwards returning load data, and raises a stall on load-use and write-after-write hazards. It sits between the decoder/ALU stage and the shared-memory response path.

Parameters:
DATA_W, 16, register and memory data width
NUM_REGS, 32, number of registers; R0 is hardwired to zero
IDX_W, $clog2(NUM_REGS), register index width (derived)
LOAD_LAT, 2, cycles from load issue to mem_rdata valid; must be at least 1
CNT_W, $clog2(LOAD_LAT+1), outstanding-load counter width (derived)

Ports:
system1000  in  1  clock
system1000_rstn  in  1  asynchronous active-low reset
rd_a_idx  in  IDX_W  read port A index
rd_a_data  out  DATA_W  read port A data (combinational)
rd_b_idx  in  IDX_W  read port B index
rd_b_data  out  DATA_W  read port B data (combinational)
alu_we  in  1  ALU writeback enable
alu_wr_idx  in  IDX_W  ALU destination
alu_wr_data  in  DATA_W  ALU result
ld_issue  in  1  load issued this cycle
ld_dst  in  IDX_W  load destination register
mem_rdata  in  DATA_W  shared-memory response data, sampled only in a completing cycle
ld_flush  in  1  kill all in-flight loads
stall  out  1  hazard detected (combinational)
ld_outstanding  out  CNT_W  number of valid pipeline stages
collision_err  out  1  sticky flag: ALU and load wrote the same register in the same cycle

Behaviour:
- Reset (asynchronous, active-low): all registers 0, all stage valids 0, collision_err 0. Outputs therefore reset to rd_*_data=0, stall=0, ld_outstanding=0.
- Load pipeline: stages s[1..LOAD_LAT], each holding {valid, dst}. A load issued in cycle t occupies s[k] during cycle t+k. s[LOAD_LAT] is the completing stage. mem_rdata is valid in cycle t+LOAD_LAT and is written to reg[dst] at the end of that cycle.
- ld_issue with ld_dst=0 creates no entry and is not counted.
- Reads: index 0 returns 0. Otherwise, if s[LOAD_LAT] is valid and its dst equals the index, mem_rdata is returned (bypass). Otherwise the array value is returned. ALU writes are not bypassed; they are visible from the next cycle.
- stall=1 if any valid s[k] with k<LOAD_LAT has a dst matching any of:
  - non-zero rd_a_idx;
  - non-zero rd_b_idx;
  - alu_wr_idx when alu_we=1;
  - ld_dst when ld_issue=1.
  With LOAD_LAT=1, stall is therefore always 0.
- stall is advisory only. The block still performs every write and issue presented to it.
- Writes to index 0 are ignored.
- Same-cycle collision: if alu_we=1 and the completing load targets the same register, the load data wins and collision_err is set. collision_err clears only on reset.
- Different-register ALU and load writes in the same cycle both complete.
- ld_flush=1: all valids clear at the clock edge, including the completing stage, so mem_rdata is not written that cycle. A simultaneous ld_issue is dropped. Bypass and stall still evaluate normally during the flush cycle.
- ld_outstanding is the popcount of the stage valids. Its maximum is LOAD_LAT; a load can be issued every cycle, and the pipeline cannot overflow.
- Reset asserted mid-load discards the load; no write occurs after reset deasserts.

Decomposition:
- Package sprockell_pkg holds:
  - DATA_W and NUM_REGS defaults;
  - typedef reg_idx_t;
  - typedef ld_entry_t {valid, dst};
  - constant REG_ZERO=0.
- Sub-module sprockell_ld_delay: parametrised LOAD_LAT shift pipeline of ld_entry_t with flush. It exposes all stages for the hazard compare and the popcount.

Test Plan:
- Reset, then read r0..r31 -> all 0; stall=0, ld_outstanding=0.
- alu_we r7=0x00A5 at cycle 0, read r7 in cycle 0 -> 0x0000; read r7 in cycle 1 -> 0x00A5. Write to r0=0xFFFF -> r0 reads 0.
- LOAD_LAT=2, ld_issue r7 at cycle 0, rd_a_idx=7:
  - cycle 1 -> stall=1, ld_outstanding=1;
  - cycle 2 with mem_rdata=0x1234 -> rd_a_data=0x1234 (bypass), stall=0;
  - cycle 3 -> array returns 0x1234.
- Back-to-back loads to r3,r4,r5 in cycles 0-2 -> ld_outstanding reaches 2; data 0x0003/0x0004/0x0005 land in the correct registers in cycles 2/3/4.
- Load to r9 completing in the same cycle as alu_we r9=0x7777 with mem_rdata=0x1111 -> r9=0x1111, collision_err=1 persisting until reset.
- ld_issue r6 at cycle 0, ld_flush at cycle 1 -> ld_outstanding=0 at cycle 2; mem_rdata 0xBEEF is ignored and r6 stays at its old value. Reset asserted while a load is pending -> everything clears immediately.
